// File: rtl/ctrl_pkg.sv
// Shared constants for the SAP control sequencer: control-bit positions,
// opcodes and the two fetch-cycle control words.
package ctrl_pkg;

  localparam int HLT_BIT = 15;
  localparam int MI_BIT  = 14;
  localparam int RI_BIT  = 13;
  localparam int RO_BIT  = 12;
  localparam int IO_BIT  = 11;
  localparam int II_BIT  = 10;
  localparam int AI_BIT  = 9;
  localparam int AO_BIT  = 8;
  localparam int EO_BIT  = 7;
  localparam int SU_BIT  = 6;
  localparam int BI_BIT  = 5;
  localparam int OI_BIT  = 4;
  localparam int CE_BIT  = 3;
  localparam int CO_BIT  = 2;
  localparam int J_BIT   = 1;
  localparam int FI_BIT  = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [15:0] FETCH0_WORD = 16'h4004;  // MI|CO
  localparam logic [15:0] FETCH1_WORD = 16'h1408;  // RO|II|CE

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the clock block / IR / ALU side.
// The master side drives step, opcode, gated clock and ALU status.
interface control_sequencer_if;
  logic        out_clock;
  logic [2:0]  step;
  logic [3:0]  opcode;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] ctrl;
  logic        flag_c;
  logic        flag_z;
  logic        halt;
  logic        step_strobe;

  modport master (
    output out_clock, step, opcode, alu_carry, alu_zero,
    input  ctrl, flag_c, flag_z, halt, step_strobe
  );

  modport slave (
    input  out_clock, step, opcode, alu_carry, alu_zero,
    output ctrl, flag_c, flag_z, halt, step_strobe
  );
endinterface

// File: rtl/ctrl_rom.sv
// Combinational microcode lookup: (step, opcode, flags) -> 16-bit control word.
module ctrl_rom
  import ctrl_pkg::*;
(
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] word
);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    word = '0;
    case (step)
      3'd0: word = FETCH0_WORD;
      3'd1: word = FETCH1_WORD;
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = 16'h4800;  // IO|MI
          OP_LDI: word = 16'h0A00;
          OP_JMP: word = 16'h0802;
          OP_JC:  word = flag_c ? 16'h0802 : 16'h0000;
          OP_JZ:  word = flag_z ? 16'h0802 : 16'h0000;
          OP_OUT: word = 16'h0110;
          OP_HLT: word = 16'h8000;
          default: word = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         word = 16'h1200;
          OP_ADD, OP_SUB: word = 16'h1020;
          OP_STA:         word = 16'h2100;
          default:        word = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  word = 16'h0281;
          OP_SUB:  word = 16'h02C1;
          default: word = '0;
        endcase
      end
      default: word = '0;  // steps 5-7 are not legal counter values
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP microcode control unit: registers the control word on every step change,
// latches ALU flags on CPU rising edges when FI is set, and holds a sticky halt.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic                  system_clock,
  input  logic                  clr,
  control_sequencer_if.slave    bus
);

  logic [2:0]  step_q;
  logic        clk_q;
  logic [15:0] ctrl_q;
  logic        flag_c_q;
  logic        flag_z_q;
  logic        halt_q;
  logic        strobe_q;
  logic [15:0] rom_word;
  logic        step_changed;
  logic        cpu_rise;
  logic [15:0] next_ctrl;

  // The ROM sees the flags as registered before this cycle, so a flag capture
  // in the same cycle cannot steer a JC/JZ decode.
  ctrl_rom u_rom (
    .step   (bus.step),
    .opcode (bus.opcode),
    .flag_c (flag_c_q),
    .flag_z (flag_z_q),
    .word   (rom_word)
  );

  assign step_changed = (bus.step != step_q);
  assign cpu_rise     = bus.out_clock & ~clk_q;
  assign next_ctrl    = step_changed ? rom_word : ctrl_q;

  always_ff @(posedge system_clock or posedge clr) begin
    if (clr) begin
      step_q   <= '0;
      clk_q    <= 1'b0;
      ctrl_q   <= FETCH0_WORD;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      halt_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values (e.g. FI of the old ctrl).
      step_q   <= bus.step;
      clk_q    <= bus.out_clock;
      ctrl_q   <= next_ctrl;
      strobe_q <= step_changed;
      if (cpu_rise && ctrl_q[FI_BIT]) begin
        flag_c_q <= bus.alu_carry;
        flag_z_q <= bus.alu_zero;
      end
      halt_q <= halt_q | next_ctrl[HLT_BIT];
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.halt        = halt_q;
  assign bus.step_strobe = strobe_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table of step/opcode changes
// plus hand sequences for flags, halt, opcode stability, illegal step and clr.
module tb_control_sequencer;

  typedef struct {
    logic [2:0]  step;
    logic [3:0]  opcode;
    logic [15:0] exp_ctrl;
  } vec_t;

  logic system_clock;
  logic clr;
  control_sequencer_if bus ();

  control_sequencer dut (
    .system_clock (system_clock),
    .clr          (clr),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_prev;
  logic        model_halt;
  vec_t        vecs[$];

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Change step/opcode away from the clock edge, then verify the one-cycle
  // update latency, the single strobe pulse and the halt model.
  task automatic do_step(input logic [2:0] s, input logic [3:0] op, input logic [15:0] exp, input string tag);
    @(negedge system_clock);
    bus.step   = s;
    bus.opcode = op;
    #1 check({tag, " hold"}, bus.ctrl, exp_prev);
    @(posedge system_clock); #1;
    check({tag, " ctrl"}, bus.ctrl, exp);
    check({tag, " strobe"}, {15'd0, bus.step_strobe}, 16'd1);
    if (exp == 16'h8000) model_halt = 1'b1;
    check({tag, " halt"}, {15'd0, bus.halt}, {15'd0, model_halt});
    @(posedge system_clock); #1;
    check({tag, " strobe low"}, {15'd0, bus.step_strobe}, 16'd0);
    check({tag, " ctrl held"}, bus.ctrl, exp);
    exp_prev = exp;
  endtask

  task automatic cpu_pulse(input logic c, input logic z, input logic exp_c, input logic exp_z, input string tag);
    @(negedge system_clock);
    bus.out_clock = 1'b1;
    bus.alu_carry = c;
    bus.alu_zero  = z;
    @(negedge system_clock);
    bus.out_clock = 1'b0;
    #1;
    check({tag, " flag_c"}, {15'd0, bus.flag_c}, {15'd0, exp_c});
    check({tag, " flag_z"}, {15'd0, bus.flag_z}, {15'd0, exp_z});
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctrl"}, bus.ctrl, 16'h4004);
    check({tag, " halt"}, {15'd0, bus.halt}, 16'd0);
    check({tag, " flag_c"}, {15'd0, bus.flag_c}, 16'd0);
    check({tag, " flag_z"}, {15'd0, bus.flag_z}, 16'd0);
    check({tag, " strobe"}, {15'd0, bus.step_strobe}, 16'd0);
  endtask

  initial begin
    vecs.push_back('{3'd1, 4'h1, 16'h1408});
    vecs.push_back('{3'd2, 4'h1, 16'h4800});
    vecs.push_back('{3'd3, 4'h1, 16'h1200});
    vecs.push_back('{3'd4, 4'h1, 16'h0000});
    vecs.push_back('{3'd0, 4'h1, 16'h4004});
    vecs.push_back('{3'd1, 4'h4, 16'h1408});
    vecs.push_back('{3'd2, 4'h4, 16'h4800});
    vecs.push_back('{3'd3, 4'h4, 16'h2100});
    vecs.push_back('{3'd4, 4'h4, 16'h0000});
    vecs.push_back('{3'd0, 4'h5, 16'h4004});
    vecs.push_back('{3'd1, 4'h5, 16'h1408});
    vecs.push_back('{3'd2, 4'h5, 16'h0A00});
    vecs.push_back('{3'd3, 4'h5, 16'h0000});
    vecs.push_back('{3'd0, 4'h6, 16'h4004});
    vecs.push_back('{3'd1, 4'h6, 16'h1408});
    vecs.push_back('{3'd2, 4'h6, 16'h0802});
    vecs.push_back('{3'd0, 4'hE, 16'h4004});
    vecs.push_back('{3'd1, 4'hE, 16'h1408});
    vecs.push_back('{3'd2, 4'hE, 16'h0110});
    vecs.push_back('{3'd0, 4'h3, 16'h4004});
    vecs.push_back('{3'd1, 4'h3, 16'h1408});
    vecs.push_back('{3'd2, 4'h3, 16'h4800});
    vecs.push_back('{3'd3, 4'h3, 16'h1020});
    vecs.push_back('{3'd4, 4'h3, 16'h02C1});
    vecs.push_back('{3'd0, 4'h7, 16'h4004});
    vecs.push_back('{3'd1, 4'h7, 16'h1408});
    vecs.push_back('{3'd2, 4'h7, 16'h0000});  // JC with carry clear
    vecs.push_back('{3'd0, 4'h9, 16'h4004});
    vecs.push_back('{3'd2, 4'h9, 16'h0000});  // unlisted opcode
    vecs.push_back('{3'd0, 4'h2, 16'h4004});
    vecs.push_back('{3'd1, 4'h2, 16'h1408});
    vecs.push_back('{3'd2, 4'h2, 16'h4800});
    vecs.push_back('{3'd3, 4'h2, 16'h1020});

    clr           = 1'b1;
    bus.step      = 3'd0;
    bus.opcode    = 4'h1;
    bus.out_clock = 1'b0;
    bus.alu_carry = 1'b0;
    bus.alu_zero  = 1'b0;
    exp_prev      = 16'h4004;
    model_halt    = 1'b0;
    #12;
    check_reset("reset");
    @(negedge system_clock);
    clr = 1'b0;
    @(posedge system_clock); #1;
    check("idle ctrl", bus.ctrl, 16'h4004);
    check("idle strobe", {15'd0, bus.step_strobe}, 16'd0);

    foreach (vecs[i]) do_step(vecs[i].step, vecs[i].opcode, vecs[i].exp_ctrl, $sformatf("vec%0d", i));

    // FI clear at ADD step 3: a CPU edge must not move the flags.
    cpu_pulse(1'b1, 1'b1, 1'b0, 1'b0, "no FI");
    do_step(3'd4, 4'h2, 16'h0281, "add s4");
    cpu_pulse(1'b1, 1'b1, 1'b1, 1'b1, "FI set");

    do_step(3'd0, 4'h7, 16'h4004, "jc s0");
    do_step(3'd1, 4'h7, 16'h1408, "jc s1");
    do_step(3'd2, 4'h7, 16'h0802, "jc taken");
    do_step(3'd0, 4'h8, 16'h4004, "jz s0");
    do_step(3'd1, 4'h8, 16'h1408, "jz s1");
    do_step(3'd2, 4'h8, 16'h0802, "jz taken");

    do_step(3'd0, 4'h2, 16'h4004, "add2 s0");
    do_step(3'd1, 4'h2, 16'h1408, "add2 s1");
    do_step(3'd2, 4'h2, 16'h4800, "add2 s2");
    do_step(3'd3, 4'h2, 16'h1020, "add2 s3");
    do_step(3'd4, 4'h2, 16'h0281, "add2 s4");
    cpu_pulse(1'b0, 1'b0, 1'b0, 1'b0, "flags clear");

    do_step(3'd0, 4'h8, 16'h4004, "jz2 s0");
    do_step(3'd1, 4'h8, 16'h1408, "jz2 s1");
    do_step(3'd2, 4'h8, 16'h0000, "jz not taken");
    @(negedge system_clock);
    bus.opcode = 4'h6;
    repeat (3) @(posedge system_clock);
    #1;
    check("opcode change ctrl", bus.ctrl, 16'h0000);
    check("opcode change strobe", {15'd0, bus.step_strobe}, 16'd0);

    do_step(3'd0, 4'hF, 16'h4004, "hlt s0");
    do_step(3'd1, 4'hF, 16'h1408, "hlt s1");
    do_step(3'd2, 4'hF, 16'h8000, "hlt s2");
    do_step(3'd3, 4'hF, 16'h0000, "hlt s3");
    do_step(3'd0, 4'hF, 16'h4004, "hlt wrap");
    do_step(3'd6, 4'hF, 16'h0000, "illegal step");
    do_step(3'd0, 4'h1, 16'h4004, "after illegal");
    do_step(3'd1, 4'h1, 16'h1408, "lda2 s1");
    do_step(3'd2, 4'h1, 16'h4800, "lda2 s2");
    do_step(3'd3, 4'h1, 16'h1200, "lda2 s3");

    // Asynchronous clear mid-instruction, away from any clock edge.
    #2 clr = 1'b1;
    #1 check_reset("mid clr");
    model_halt = 1'b0;
    @(negedge system_clock);
    clr = 1'b0;
    @(posedge system_clock); #1;
    check("post clr ctrl", bus.ctrl, 16'h1200);
    check("post clr strobe", {15'd0, bus.step_strobe}, 16'd1);
    check("post clr halt", {15'd0, bus.halt}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
